// File: rtl/nes_pad_reader.sv
// NES controller poller: on each frame strobe, latches the pad, clocks out its
// eight serial button bits and presents them as an active-high registered byte.
module nes_pad_reader #(
  parameter int TICKS_6US = 150
) (
  input  logic       pixel_Clk,
  input  logic       Reset,
  input  logic       VSyncStart,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons,
  output logic       buttons_valid,
  output logic       busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LATCH  = 3'd1;
  localparam logic [2:0] SAMPLE = 3'd2;
  localparam logic [2:0] PULSE  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [12:0] LATCH_LAST = 13'(2 * TICKS_6US - 1);
  localparam logic [12:0] PHASE_LAST = 13'(TICKS_6US - 1);

  logic [2:0]  state_reg, state_next;
  logic [12:0] phase_reg, phase_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  shift_reg, shift_next;
  logic [1:0]  sync_reg;
  logic        nes_latch_reg, nes_clk_reg, buttons_valid_reg, busy_reg;
  logic [7:0]  buttons_reg;
  logic        phase_done;
  logic        capture;
  logic        data_sync;

  assign data_sync  = sync_reg[1];
  assign phase_done = (state_reg == LATCH) ? (phase_reg == LATCH_LAST)
                                           : (phase_reg == PHASE_LAST);

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    bit_next   = bit_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (VSyncStart) begin
          state_next = LATCH;
          phase_next = '0;
          bit_next   = '0;
        end
      end
      LATCH: begin
        if (phase_done) begin
          state_next = SAMPLE;
          phase_next = '0;
        end else begin
          phase_next = phase_reg + 13'd1;
        end
      end
      SAMPLE: begin
        if (phase_done) begin
          capture    = 1'b1;
          phase_next = '0;
          state_next = (bit_reg == 3'd7) ? DONE : PULSE;
        end else begin
          phase_next = phase_reg + 13'd1;
        end
      end
      PULSE: begin
        if (phase_done) begin
          state_next = SAMPLE;
          phase_next = '0;
          bit_next   = bit_reg + 3'd1;
        end else begin
          phase_next = phase_reg + 13'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The pad drives active-low data; each bit lands in its own slot so the
  // final bit can be folded into the byte in the same edge that enters DONE.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_shift
      assign shift_next[gi] = (capture && (bit_reg == 3'(gi))) ? ~data_sync
                                                               : shift_reg[gi];
    end
  endgenerate

  always_ff @(posedge pixel_Clk) begin
    if (Reset) begin
      state_reg         <= IDLE;
      phase_reg         <= '0;
      bit_reg           <= '0;
      shift_reg         <= '0;
      sync_reg          <= 2'b11;
      nes_latch_reg     <= 1'b0;
      nes_clk_reg       <= 1'b0;
      buttons_reg       <= '0;
      buttons_valid_reg <= 1'b0;
      busy_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      phase_reg         <= phase_next;
      bit_reg           <= bit_next;
      shift_reg         <= shift_next;
      sync_reg          <= {sync_reg[0], nes_data};
      // Outputs decode the next state so they are clean flops aligned to it.
      nes_latch_reg     <= (state_next == LATCH);
      nes_clk_reg       <= (state_next == PULSE);
      busy_reg          <= (state_next != IDLE);
      buttons_valid_reg <= (state_next == DONE);
      if (state_next == DONE)
        buttons_reg <= shift_next;
    end
  end

  assign nes_latch     = nes_latch_reg;
  assign nes_clk       = nes_clk_reg;
  assign buttons       = buttons_reg;
  assign buttons_valid = buttons_valid_reg;
  assign busy          = busy_reg;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: behavioural pad model, scoreboard of expected
// button bytes and poll latencies, plus per-cycle protocol monitors.
module tb_nes_pad_reader;

  localparam int T   = 4;
  localparam int LAT = 17 * T + 1;

  logic       pixel_Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       VSyncStart = 1'b0;
  logic       nes_data;
  logic       nes_latch, nes_clk;
  logic [7:0] buttons;
  logic       buttons_valid, busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0] pressed = 8'h00;
  logic       const_one = 1'b0;
  logic [7:0] pad_sr = 8'hFF;
  logic       pad_clk_d = 1'b0;

  typedef struct {
    logic [7:0] btn;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  nes_pad_reader #(.TICKS_6US(T)) dut (
    .pixel_Clk    (pixel_Clk),
    .Reset        (Reset),
    .VSyncStart   (VSyncStart),
    .nes_data     (nes_data),
    .nes_latch    (nes_latch),
    .nes_clk      (nes_clk),
    .buttons      (buttons),
    .buttons_valid(buttons_valid),
    .busy         (busy)
  );

  always #5 pixel_Clk = ~pixel_Clk;

  always @(posedge pixel_Clk) cyc <= cyc + 1;

  // Pad model: reloads while latched, shifts on each nes_clk rising edge.
  always @(posedge pixel_Clk) begin
    if (nes_latch)
      pad_sr <= ~pressed;
    else if (nes_clk && !pad_clk_d)
      pad_sr <= {1'b1, pad_sr[7:1]};
    pad_clk_d <= nes_clk;
  end
  assign nes_data = const_one ? 1'b1 : pad_sr[0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  int  busy_cnt = 0, latch_cnt = 0, clk_cnt = 0, latch_len = 0, clk_len = 0;
  logic latch_prev = 1'b0, clk_prev = 1'b0;

  always @(negedge pixel_Clk) begin
    exp_t e;
    check("overlap", {31'd0, nes_latch & nes_clk}, 32'd0);
    if (busy) busy_cnt++;
    if (nes_latch) begin
      if (!latch_prev) latch_cnt++;
      latch_len++;
    end else if (latch_prev) begin
      check("latch_len", latch_len, 2 * T);
      latch_len = 0;
    end
    if (nes_clk) begin
      if (!clk_prev) clk_cnt++;
      clk_len++;
    end else if (clk_prev) begin
      check("clk_len", clk_len, T);
      clk_len = 0;
    end
    latch_prev = nes_latch;
    clk_prev   = nes_clk;
    if (buttons_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("buttons", {24'd0, buttons}, {24'd0, e.btn});
        check("latency", cyc - e.cyc, LAT);
        check("busy_len", busy_cnt, LAT);
        check("latch_cnt", latch_cnt, 1);
        check("clk_cnt", clk_cnt, 7);
        $display("poll done: buttons=%02h latency=%0d", buttons, cyc - e.cyc);
      end
      busy_cnt = 0; latch_cnt = 0; clk_cnt = 0;
    end
    if (Reset) begin
      busy_cnt = 0; latch_cnt = 0; clk_cnt = 0; latch_len = 0; clk_len = 0;
      latch_prev = 1'b0; clk_prev = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pixel_Clk);
    #1;
  endtask

  task automatic start_poll(input logic [7:0] p, input bit expect_done);
    exp_t e;
    pressed = p;
    VSyncStart = 1'b1;
    if (expect_done) begin
      e.btn = const_one ? 8'h00 : p;
      e.cyc = cyc;
      sb.push_back(e);
    end
    tick(1);
    VSyncStart = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    check("drain", sb.size(), 0);
    tick(3);
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    tick(3);
    check("rst_buttons", {24'd0, buttons}, 32'd0);
    check("rst_valid", {31'd0, buttons_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_latch", {31'd0, nes_latch}, 32'd0);
    check("rst_clk", {31'd0, nes_clk}, 32'd0);
    Reset = 1'b0;
    tick(5);
    check("no_autostart", {31'd0, busy}, 32'd0);

    const_one = 1'b1;
    start_poll(8'h00, 1'b1);
    wait_drain();
    const_one = 1'b0;

    start_poll(8'h88, 1'b1);
    wait_drain();
    start_poll(8'hFF, 1'b1);
    wait_drain();
    start_poll(8'h00, 1'b1);
    wait_drain();

    // Extra strobes mid-poll must be ignored.
    start_poll(8'h5A, 1'b1);
    tick(9);
    VSyncStart = 1'b1; tick(1); VSyncStart = 1'b0;
    tick(29);
    VSyncStart = 1'b1; tick(1); VSyncStart = 1'b0;
    wait_drain();

    // Reset mid-poll aborts it.
    start_poll(8'h01, 1'b0);
    tick(29);
    Reset = 1'b1; tick(1); Reset = 1'b0;
    @(negedge pixel_Clk);
    check("abort_latch", {31'd0, nes_latch}, 32'd0);
    check("abort_clk", {31'd0, nes_clk}, 32'd0);
    check("abort_buttons", {24'd0, buttons}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    tick(1);
    tick(80);
    check("abort_hold", {24'd0, buttons}, 32'd0);

    // Reset wins over a simultaneous strobe.
    pressed = 8'hC3;
    Reset = 1'b1; VSyncStart = 1'b1; tick(1);
    Reset = 1'b0; VSyncStart = 1'b0;
    @(negedge pixel_Clk);
    check("rst_vs_busy", {31'd0, busy}, 32'd0);
    tick(1);
    tick(80);
    check("rst_vs_idle", {31'd0, busy}, 32'd0);
    check("rst_vs_buttons", {24'd0, buttons}, 32'd0);

    start_poll(8'h3C, 1'b1);
    wait_drain();
    start_poll(8'($urandom_range(0, 255)), 1'b1);
    wait_drain();
    tick(10);
    check("buttons_hold", {24'd0, buttons}, {24'd0, pressed});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
